// File: rtl/fft_pipe_pkg.sv
// rtl/fft_pipe_pkg.sv - shared constants, state codes and token type for the FFT pipeline sequencer
package fft_pipe_pkg;

    localparam int LANES           = 32;
    localparam int NSTAGE_DEF      = 5;
    localparam int FRAME_BEATS_DEF = 8;
    localparam int BW_DEF          = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    // Beat index travels beside this struct so its width can follow the BW parameter.
    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } tok_flags_t;

    function automatic logic start_is_error(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_DRAIN) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/fft_tok_shift.sv
// rtl/fft_tok_shift.sv - token shift register that mirrors the datapath bank chain, one slot per bank
module fft_tok_shift
    import fft_pipe_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int BW     = BW_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 in_eof,
    input  logic [BW-1:0]        in_beat,
    output logic [NSTAGE-1:0]    stage_valid,
    output logic [NSTAGE*BW-1:0] stage_beat,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof
);

    tok_flags_t        tok_q  [NSTAGE];
    tok_flags_t        tok_d  [NSTAGE];
    logic [BW-1:0]     beat_q [NSTAGE];
    logic [BW-1:0]     beat_d [NSTAGE];

    always_comb begin
        tok_d[0]  = '{valid: in_valid, sof: in_sof, eof: in_eof};
        beat_d[0] = in_valid ? in_beat : '0;
        for (int k = 1; k < NSTAGE; k++) begin
            tok_d[k]  = tok_q[k-1];
            beat_d[k] = beat_q[k-1];
        end
        if (clr) begin
            for (int k = 0; k < NSTAGE; k++) begin
                tok_d[k]  = '0;
                beat_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        tok_q  <= tok_d;
        beat_q <= beat_d;
    end

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            stage_valid[k]          = tok_q[k].valid;
            stage_beat[k*BW +: BW]  = beat_q[k];
        end
        out_valid = tok_q[NSTAGE-1].valid;
        out_sof   = tok_q[NSTAGE-1].sof;
        out_eof   = tok_q[NSTAGE-1].eof;
    end

endmodule

// File: rtl/fft_pipe_ctrl.sv
// rtl/fft_pipe_ctrl.sv - frame sequencer: tags beats through the bank chain, clears banks, counts frames
module fft_pipe_ctrl
    import fft_pipe_pkg::*;
#(
    parameter int NSTAGE      = NSTAGE_DEF,
    parameter int FRAME_BEATS = FRAME_BEATS_DEF,
    parameter int BW          = BW_DEF,
    parameter int FCW         = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NSTAGE-1:0]    stage_rstb,
    output logic [NSTAGE-1:0]    stage_valid,
    output logic [NSTAGE*BW-1:0] stage_beat,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 done,
    output logic [FCW-1:0]       frame_cnt,
    output logic                 err_overrun,
    output logic                 err_start
);

    logic [2:0]        state_q, state_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic [NSTAGE-1:0] stage_rstb_q, stage_rstb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic              err_overrun_q, err_overrun_d;
    logic              err_start_q, err_start_d;

    logic accept;
    logic last_beat;
    logic tok_clr;

    always_comb begin
        accept    = in_ready_q && in_valid && !flush;
        last_beat = (cnt_q == BW'(FRAME_BEATS - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt_d = last_beat ? '0 : cnt_q + BW'(1);
                        if (last_beat) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_eof) state_d = ST_DONE;
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_FLUSH: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        in_ready_d    = (state_d == ST_RUN);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        stage_rstb_d  = {NSTAGE{state_d != ST_FLUSH}};
        frame_cnt_d   = frame_cnt_q;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) frame_cnt_d = frame_cnt_q + FCW'(1);

        // A start that loses to flush is not an error, even mid-frame.
        err_overrun_d = err_overrun_q | (in_valid && !in_ready_q);
        err_start_d   = err_start_q | (start && !flush && start_is_error(state_q));
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            in_ready_q    <= 1'b0;
            stage_rstb_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_cnt_q   <= '0;
            err_overrun_q <= 1'b0;
            err_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            stage_rstb_q  <= stage_rstb_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_overrun_q <= err_overrun_d;
            err_start_q   <= err_start_d;
        end
    end

    // Tokens are wiped on the same edge that asserts the bank clears, so tags never outlive data.
    assign tok_clr = !rstb || (state_d == ST_FLUSH);

    fft_tok_shift #(
        .NSTAGE (NSTAGE),
        .BW     (BW)
    ) u_tok_shift (
        .clk         (clk),
        .clr         (tok_clr),
        .in_valid    (accept),
        .in_sof      (accept && (cnt_q == '0)),
        .in_eof      (accept && last_beat),
        .in_beat     (cnt_q),
        .stage_valid (stage_valid),
        .stage_beat  (stage_beat),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof)
    );

    assign in_ready    = in_ready_q;
    assign stage_rstb  = stage_rstb_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_overrun = err_overrun_q;
    assign err_start   = err_start_q;

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// tb/tb_fft_pipe_ctrl.sv - directed and randomized self-checking bench for fft_pipe_ctrl
module tb_fft_pipe_ctrl;

    localparam int NST = 5;
    localparam int FB  = 8;
    localparam int BWI = 3;
    localparam int FCW = 16;

    logic clk, rstb, start, flush, in_valid;
    logic in_ready, out_valid, out_sof, out_eof, busy, done, err_overrun, err_start;
    logic [NST-1:0]     stage_rstb, stage_valid;
    logic [NST*BWI-1:0] stage_beat;
    logic [FCW-1:0]     frame_cnt;

    fft_pipe_ctrl dut (
        .clk(clk), .rstb(rstb), .start(start), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .stage_rstb(stage_rstb), .stage_valid(stage_valid),
        .stage_beat(stage_beat), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .err_overrun(err_overrun), .err_start(err_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bank contents kept as a history of beat numbers (-1 = bubble).
    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE, M_FLUSH} mode_t;
    mode_t mode = M_IDLE;
    int    hist [NST];
    int    cnt = 0;
    int    m_fc = 0;
    bit    m_ovr = 0, m_sst = 0, m_done = 0, m_srst = 0;
    bit    model_on = 0;

    initial for (int k = 0; k < NST; k++) hist[k] = -1;

    always @(posedge clk) begin
        if (!rstb) begin
            mode = M_IDLE; cnt = 0; m_fc = 0; m_ovr = 0; m_sst = 0; m_done = 0; m_srst = 0;
            for (int k = 0; k < NST; k++) hist[k] = -1;
            model_on = 1;
        end else begin
            bit    acc;
            mode_t nm;
            acc = (mode == M_RUN) && in_valid && !flush;
            if (in_valid && mode != M_RUN) m_ovr = 1;
            if (start && !flush && (mode == M_RUN || mode == M_DRAIN || mode == M_DONE)) m_sst = 1;
            nm = mode;
            if (flush) nm = M_FLUSH;
            else if (mode == M_IDLE && start) begin nm = M_RUN; cnt = 0; end
            else if (mode == M_RUN && acc && cnt == FB-1) nm = M_DRAIN;
            else if (mode == M_DRAIN && hist[NST-1] == FB-1) nm = M_DONE;
            else if (mode == M_DONE || mode == M_FLUSH) nm = M_IDLE;
            if (flush) begin
                for (int k = 0; k < NST; k++) hist[k] = -1;
            end else begin
                for (int k = NST-1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = acc ? cnt : -1;
            end
            if (acc) cnt = (cnt + 1) % FB;
            m_done = (nm == M_DONE);
            if (m_done && mode != M_DONE) m_fc = (m_fc + 1) % (1 << FCW);
            m_srst = (nm != M_FLUSH);
            mode = nm;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            logic [NST-1:0]     ev;
            logic [NST*BWI-1:0] eb;
            for (int k = 0; k < NST; k++) begin
                ev[k] = (hist[k] >= 0);
                eb[k*BWI +: BWI] = (hist[k] >= 0) ? BWI'(hist[k]) : '0;
            end
            chk("m_in_ready",    in_ready,    mode == M_RUN);
            chk("m_stage_rstb",  stage_rstb,  {NST{m_srst}});
            chk("m_stage_valid", stage_valid, ev);
            chk("m_stage_beat",  stage_beat,  eb);
            chk("m_out_valid",   out_valid,   hist[NST-1] >= 0);
            chk("m_out_sof",     out_sof,     hist[NST-1] == 0);
            chk("m_out_eof",     out_eof,     hist[NST-1] == FB-1);
            chk("m_busy",        busy,        mode != M_IDLE);
            chk("m_done",        done,        m_done);
            chk("m_frame_cnt",   frame_cnt,   m_fc);
            chk("m_err_overrun", err_overrun, m_ovr);
            chk("m_err_start",   err_start,   m_sst);
        end
    end

    // Inputs change 2 time units after a rising edge; the task returns at the same point of the next cycle.
    task automatic step(input bit s, input bit f, input bit v, input bit r = 1'b1);
        start = s; flush = f; in_valid = v; rstb = r;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input bit alt, input bit mid_start);
        int acc = 0;
        int c = 0;
        int done_at = -1;
        step(1, 0, 0);
        while (acc < FB && c < 100) begin
            bit v;
            v = alt ? (c % 2 == 0) : 1'b1;
            if (v) acc++;
            step(mid_start && c == 2, 0, v);
            c++;
        end
        for (int w = 0; w < 30; w++) begin
            if (done) begin done_at = w; break; end
            step(0, 0, 0);
        end
        chk("frame_done_seen", done_at >= 0, 1);
        step(0, 0, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [FCW-1:0] fc0;
        rstb = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #2;
        step(0, 0, 0, 0);
        chk("rst_stage_rstb", stage_rstb, 5'b00000);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_out_valid", out_valid, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("rel_stage_rstb", stage_rstb, 5'b11111);

        // Single full frame: start in cycle 0, beats in cycles 1..8.
        for (int c = 0; c <= 16; c++) begin
            if (c >= 1 && c <= 8) chk("s1_in_ready_hi", in_ready, 1);
            if (c == 9)  chk("s1_in_ready_lo", in_ready, 0);
            chk("s1_out_valid", out_valid, (c >= 6 && c <= 13));
            if (c == 6)  chk("s1_sof6", out_sof, 1);
            if (c == 8)  chk("s1_beat2", stage_beat[4*BWI +: BWI], 3'd2);
            if (c == 13) chk("s1_eof13", out_eof, 1);
            chk("s1_done", done, c == 14);
            if (c == 15) begin
                chk("s1_busy15", busy, 0);
                chk("s1_fcnt15", frame_cnt, 1);
            end
            step(c == 0, 0, (c >= 1 && c <= 8));
        end

        // Flush after three accepted beats; the beat coinciding with flush is dropped.
        step(1, 0, 0);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(0, 1, 1);
        chk("fl_stage_rstb", stage_rstb, 5'b00000);
        chk("fl_stage_valid", stage_valid, 5'b00000);
        step(0, 0, 0);
        chk("fl_rstb_back", stage_rstb, 5'b11111);
        chk("fl_valid_next", stage_valid, 5'b00000);
        chk("fl_busy", busy, 0);
        for (int w = 0; w < 12; w++) begin
            chk("fl_no_done", done, 0);
            chk("fl_no_eof", out_eof, 0);
            step(0, 0, 0);
        end
        chk("fl_fcnt", frame_cnt, 1);

        // Error flags: overrun in IDLE, then start during RUN; frame still completes.
        step(0, 0, 1);
        chk("er_overrun", err_overrun, 1);
        chk("er_start_clear", err_start, 0);
        frame(0, 1);
        chk("er_start", err_start, 1);
        chk("er_fcnt", frame_cnt, 2);
        frame(1, 0);
        fc0 = frame_cnt;
        frame(0, 0);
        chk("b2b_fcnt", frame_cnt, fc0 + 16'd1);
        chk("er_overrun_held", err_overrun, 1);
        chk("er_start_held", err_start, 1);

        // Reset during DRAIN.
        step(1, 0, 0);
        for (int i = 0; i < FB; i++) step(0, 0, 1);
        step(0, 0, 0);
        chk("dr_busy", busy, 1);
        step(0, 0, 0, 0);
        chk("dr_stage_rstb", stage_rstb, 5'b00000);
        chk("dr_stage_valid", stage_valid, 5'b00000);
        chk("dr_fcnt", frame_cnt, 0);
        chk("dr_errs", {err_overrun, err_start}, 2'b00);
        chk("dr_busy_rst", busy, 0);
        step(0, 0, 0, 1);
        chk("dr_rstb_back", stage_rstb, 5'b11111);
        chk("dr_idle", busy, 0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            bit s, f, v, r;
            r = ($urandom_range(0, 399) != 0);
            f = ($urandom_range(0, 79) == 0);
            s = (mode == M_IDLE) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            v = (mode == M_RUN) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 59) == 0);
            step(s, f, v, r);
        end
        step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
